// File: rtl/param_up_down_counter.sv
// param_up_down_counter: parameterised up/down counter with load, wrap or
// optional saturate (UDC_SAT_EN), registered terminal-count and FSM state.
//
// Parameters:
//   WIDTH    - counter width in bits (>= 1)
//   MAX_VAL  - terminal value, counter spans 0..MAX_VAL
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous active-low reset
//   en       - count enable
//   dir      - 0 = count up, 1 = count down
//   load     - synchronous parallel load strobe
//   load_val - value to load (clamped to MAX_VAL)
//   sat      - 0 = wrap, 1 = saturate (only when UDC_SAT_EN is defined)
//   out      - registered count value
//   tc       - registered terminal-count flag
//   state    - registered FSM state: IDLE=00, UP=01, DOWN=10
// Configuration macro: UDC_SAT_EN adds the sat port and saturate mode.

module param_up_down_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef UDC_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           cur;
    logic             sat_on;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_val;
    logic             step_tc;
    logic             at_max;
    logic             at_zero;
    logic             above_max;

`ifdef UDC_SAT_EN
    assign sat_on = sat;
`else
    // Tied off so every saturate branch folds away.
    assign sat_on = 1'b0;
`endif

    assign at_max    = (out == MAX);
    assign at_zero   = (out == ZERO);
    assign above_max = (out > MAX);

    assign load_clamped = (load_val > MAX) ? MAX : load_val;

    // Next value and terminal flag for an enabled counting edge.
    // Arithmetic is modulo MAX_VAL+1: the bound checks handle the
    // roll-over explicitly instead of relying on 2**WIDTH overflow.
    always_comb begin
        step_val = out;
        step_tc  = 1'b0;
        if (!dir) begin
            if (above_max) begin
                // Out-of-range value snaps back into the legal range.
                step_val = ZERO;
            end else if (at_max) begin
                step_val = sat_on ? out : ZERO;
                step_tc  = 1'b1;
            end else begin
                step_val = out + ONE;
            end
        end else begin
            if (above_max) begin
                step_val = MAX;
            end else if (at_zero) begin
                step_val = sat_on ? out : MAX;
                step_tc  = 1'b1;
            end else begin
                step_val = out - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out <= ZERO;
            tc  <= 1'b0;
            cur <= IDLE;
        end else if (load) begin
            out <= load_clamped;
            tc  <= 1'b0;
            cur <= IDLE;
        end else if (en) begin
            out <= step_val;
            tc  <= step_tc;
            cur <= dir ? DOWN : UP;
        end else begin
            tc  <= 1'b0;
            cur <= IDLE;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_param_up_down_counter.sv
// tb_param_up_down_counter: directed scoreboard bench for two counter
// configurations (WIDTH=2/MAX=3 and WIDTH=4/MAX=9).

module tb_param_up_down_counter;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_UP   = 2'b01;
    localparam logic [1:0] S_DOWN = 2'b10;

    typedef struct {
        int         sel;
        logic [3:0] out;
        logic       tc;
        logic [1:0] st;
        string      tag;
    } exp_t;

    exp_t q[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst = 1'b0, a_en = 1'b0, a_dir = 1'b0, a_load = 1'b0;
    logic [1:0] a_lv = '0;
    logic [1:0] a_out;
    logic       a_tc;
    logic [1:0] a_st;

    logic       b_rst = 1'b0, b_en = 1'b0, b_dir = 1'b0, b_load = 1'b0;
    logic [3:0] b_lv = '0;
    logic [3:0] b_out;
    logic       b_tc;
    logic [1:0] b_st;

    logic sat_in = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    param_up_down_counter #(.WIDTH(2), .MAX_VAL(3)) dut_a (
        .clk      (clk),
        .reset    (a_rst),
        .en       (a_en),
        .dir      (a_dir),
        .load     (a_load),
        .load_val (a_lv),
`ifdef UDC_SAT_EN
        .sat      (sat_in),
`endif
        .out      (a_out),
        .tc       (a_tc),
        .state    (a_st)
    );

    param_up_down_counter #(.WIDTH(4), .MAX_VAL(9)) dut_b (
        .clk      (clk),
        .reset    (b_rst),
        .en       (b_en),
        .dir      (b_dir),
        .load     (b_load),
        .load_val (b_lv),
`ifdef UDC_SAT_EN
        .sat      (sat_in),
`endif
        .out      (b_out),
        .tc       (b_tc),
        .state    (b_st)
    );

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one edge worth of inputs, record the expectation, then
    // compare against the registered outputs just after the edge.
    task automatic step(input int sel, input logic r, input logic e,
                        input logic d, input logic l,
                        input logic [3:0] lv, input logic [3:0] eo,
                        input logic et, input logic [1:0] es,
                        input string tag);
        exp_t x;
        if (sel == 0) begin
            a_rst = r; a_en = e; a_dir = d; a_load = l; a_lv = lv[1:0];
        end else begin
            b_rst = r; b_en = e; b_dir = d; b_load = l; b_lv = lv;
        end
        q.push_back('{sel, eo, et, es, tag});
        @(posedge clk);
        #1;
        x = q.pop_front();
        if (x.sel == 0) begin
            check({x.tag, ".out"}, {2'b00, a_out}, x.out);
            check({x.tag, ".tc"}, {3'b000, a_tc}, {3'b000, x.tc});
            check({x.tag, ".st"}, {2'b00, a_st}, {2'b00, x.st});
        end else begin
            check({x.tag, ".out"}, b_out, x.out);
            check({x.tag, ".tc"}, {3'b000, b_tc}, {3'b000, x.tc});
            check({x.tag, ".st"}, {2'b00, b_st}, {2'b00, x.st});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        // W=2: reset two cycles, then count up through a wrap
        step(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE, "a_rst0");
        step(0, 0, 0, 0, 0, 0, 0, 0, S_IDLE, "a_rst1");
        step(0, 1, 1, 0, 0, 0, 1, 0, S_UP, "a_up1");
        step(0, 1, 1, 0, 0, 0, 2, 0, S_UP, "a_up2");
        step(0, 1, 1, 0, 0, 0, 3, 0, S_UP, "a_up3");
        step(0, 1, 1, 0, 0, 0, 0, 1, S_UP, "a_upwrap");
        step(0, 1, 1, 0, 0, 0, 1, 0, S_UP, "a_up5");
        step(0, 1, 1, 0, 0, 0, 2, 0, S_UP, "a_up6");
        // load 1 then count down through a wrap
        step(0, 1, 0, 0, 1, 1, 1, 0, S_IDLE, "a_load1");
        step(0, 1, 1, 1, 0, 0, 0, 0, S_DOWN, "a_dn0");
        step(0, 1, 1, 1, 0, 0, 3, 1, S_DOWN, "a_dnwrap");
        step(0, 1, 1, 1, 0, 0, 2, 0, S_DOWN, "a_dn2");
        // reset mid-count overrides load and en
        step(0, 0, 1, 0, 1, 3, 0, 0, S_IDLE, "a_midrst");
        step(0, 1, 1, 0, 0, 0, 1, 0, S_UP, "a_resume");
        // direction change without a bubble, then hold
        step(0, 1, 1, 1, 0, 0, 0, 0, S_DOWN, "a_dirchg");
        step(0, 1, 0, 1, 0, 0, 0, 0, S_IDLE, "a_hold");
`ifdef UDC_SAT_EN
        sat_in = 1'b1;
        step(0, 1, 0, 0, 1, 2, 2, 0, S_IDLE, "s_load2");
        step(0, 1, 1, 0, 0, 0, 3, 0, S_UP, "s_up3");
        step(0, 1, 1, 0, 0, 0, 3, 1, S_UP, "s_hold3a");
        step(0, 1, 1, 0, 0, 0, 3, 1, S_UP, "s_hold3b");
        step(0, 1, 1, 1, 0, 0, 2, 0, S_DOWN, "s_dn2");
        step(0, 1, 0, 0, 1, 0, 0, 0, S_IDLE, "s_load0");
        step(0, 1, 1, 1, 0, 0, 0, 1, S_DOWN, "s_hold0");
        sat_in = 1'b0;
        step(0, 1, 1, 1, 0, 0, 3, 1, S_DOWN, "s_offwrap");
`endif
        // W=4, MAX=9: clamped load, non-power-of-two wrap
        step(1, 0, 0, 0, 0, 0, 0, 0, S_IDLE, "b_rst");
        step(1, 1, 0, 0, 1, 12, 9, 0, S_IDLE, "b_clamp");
        step(1, 1, 1, 0, 0, 0, 0, 1, S_UP, "b_upwrap");
        step(1, 1, 1, 0, 1, 5, 5, 0, S_IDLE, "b_loaden");
        step(1, 1, 0, 0, 0, 0, 5, 0, S_IDLE, "b_hold1");
        step(1, 1, 0, 1, 0, 0, 5, 0, S_IDLE, "b_hold2");
        step(1, 1, 0, 0, 0, 0, 5, 0, S_IDLE, "b_hold3");
        step(1, 1, 1, 1, 0, 0, 4, 0, S_DOWN, "b_dn4");
        step(1, 1, 0, 0, 1, 0, 0, 0, S_IDLE, "b_load0");
        step(1, 1, 1, 1, 0, 0, 9, 1, S_DOWN, "b_dnwrap");
        step(1, 1, 1, 0, 0, 0, 0, 1, S_UP, "b_upwrap2");
        step(1, 1, 1, 0, 0, 0, 1, 0, S_UP, "b_up1");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_up_down_counter.md
PARAM_UP_DOWN_COUNTER -- requirements
Module: param_up_down_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; SHALL be >= 1.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal value; counter SHALL count 0..MAX_VAL; legal range 1..2**WIDTH-1.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset asserted).
REQ-005 en  input  1  count enable.
REQ-006 dir  input  1  direction: 0 = up, 1 = down.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 load_val  input  WIDTH  value loaded when load=1.
REQ-009 sat  input  1  mode select, present only with UDC_SAT_EN: 0 = wrap, 1 = saturate.
REQ-010 out  output  WIDTH  registered count value.
REQ-011 tc  output  1  registered terminal-count flag.
REQ-012 state  output  2  registered FSM state: IDLE=2'b00, UP=2'b01, DOWN=2'b10; 2'b11 never driven.

Function
REQ-013 Per-edge priority SHALL be: reset > load > en > hold.
REQ-014 load=1: out <= min(load_val, MAX_VAL); state <= IDLE; tc <= 0; en and dir ignored that cycle.
REQ-015 en=1, load=0: state <= UP if dir=0, DOWN if dir=1; out SHALL step by exactly 1 on the same edge (1-cycle latency from sampled inputs to out).
REQ-016 en=0, load=0: out holds; state <= IDLE; tc <= 0.
REQ-017 Direction change while enabled SHALL take effect on the next edge with no idle/bubble cycle.
REQ-018 Wrap, up: out=MAX_VAL -> 0, tc <= 1 on that edge.
REQ-019 Wrap, down: out=0 -> MAX_VAL, tc <= 1 on that edge.
REQ-020 tc SHALL be 0 on every counting edge that does not wrap or saturate; tc is a 1-cycle pulse per wrap in wrap mode.
REQ-021 Saturate (sat=1): up at MAX_VAL and down at 0 SHALL hold out; tc SHALL be 1 on every enabled edge where out is held at the bound.
REQ-022 If out > MAX_VAL (only possible via parameter misuse), next counting edge SHALL force out to 0 (up) or MAX_VAL (down).
REQ-023 Arithmetic SHALL be modulo MAX_VAL+1, never modulo 2**WIDTH unless MAX_VAL=2**WIDTH-1.

Reset
REQ-024 reset=0 at a rising edge SHALL set out=0, tc=0, state=IDLE, overriding load and en.
REQ-025 Reset mid-count SHALL discard any in-progress step; first count after release uses inputs sampled on the first edge with reset=1.
REQ-026 No asynchronous path from reset to any output; before the first edge outputs are undefined.

Configuration
REQ-027 Macro UDC_SAT_EN defined: sat port exists and REQ-021 applies when sat=1.
REQ-028 Macro UDC_SAT_EN undefined: sat port absent; counter SHALL always wrap per REQ-018/019; no saturate logic synthesised.

Verification
REQ-029 WIDTH=2, MAX_VAL=3, reset=0 2 cycles then en=1,dir=0 for 6 edges -> out 1,2,3,0,1,2; tc=1 only on the edge out=0; state=UP.
REQ-030 WIDTH=2, from out=1, en=1,dir=1 for 3 edges -> out 0,3,2; tc=1 on edge out=3; state=DOWN.
REQ-031 WIDTH=4, MAX_VAL=9, load=1,load_val=12 -> out=9,state=IDLE; then en=1,dir=0 one edge -> out=0, tc=1.
REQ-032 load=1 and en=1 same edge, load_val=5 (WIDTH=4, MAX_VAL=9) -> out=5, tc=0, state=IDLE; en=0 next 3 edges -> out stays 5.
REQ-033 UDC_SAT_EN, sat=1, WIDTH=2, out=2, en=1,dir=0 for 3 edges -> out 3,3,3; tc 0,1,1; dir=1 next edge -> out=2, tc=0.
REQ-034 Counting at out=2 (WIDTH=2), reset=0 with load=1,en=1 -> out=0, tc=0, state=IDLE next edge; release -> count resumes from 0.
